// File: rtl/packet_deserializer.sv
// Collects four 16-bit beats into a header/addr/data packet with
// valid/ready output, frame checking, resync and error counting.
module packet_deserializer #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_bits,
   input  logic                 in_last,
   output logic [15:0]          inPacket_tx_header,
   output logic [15:0]          inPacket_tx_addr,
   output logic [31:0]          inPacket_tx_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic {
      COLLECT,
      RESYNC
   } stateT;

   stateT       state;
   stateT       stateNext;
   logic [1:0]  cnt;
   logic [1:0]  cntNext;
   logic [15:0] hdrShadow;
   logic [15:0] addrShadow;
   logic [15:0] dataLoShadow;
   logic        beatFire;
   logic        loadOut;
   logic        frameErr;

   // Only the final beat needs the output slot; earlier beats go to shadows.
   assign in_ready = (state == RESYNC) || (cnt != 2'd3)
                   || !out_valid || out_ready;
   assign beatFire = in_valid && in_ready;

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      loadOut   = 1'b0;
      frameErr  = 1'b0;
      unique case (state)
         COLLECT: begin
            if (beatFire) begin
               if (in_last) begin
                  cntNext = 2'd0;
                  if (cnt == 2'd3) loadOut = 1'b1;
                  else             frameErr = 1'b1;
               end else if (cnt == 2'd3) begin
                  cntNext   = 2'd0;
                  frameErr  = 1'b1;
                  stateNext = RESYNC;
               end else begin
                  cntNext = cnt + 2'd1;
               end
            end
         end
         RESYNC: begin
            if (beatFire && in_last) stateNext = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state              <= COLLECT;
         cnt                <= 2'd0;
         hdrShadow          <= '0;
         addrShadow         <= '0;
         dataLoShadow       <= '0;
         inPacket_tx_header <= '0;
         inPacket_tx_addr   <= '0;
         inPacket_tx_data   <= '0;
         out_valid          <= 1'b0;
         err_pulse          <= 1'b0;
         err_count          <= '0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         err_pulse <= frameErr;
         if (frameErr && (err_count != {ERR_CNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
         if (beatFire && (state == COLLECT) && !in_last) begin
            if (cnt == 2'd0) hdrShadow    <= in_bits;
            if (cnt == 2'd1) addrShadow   <= in_bits;
            if (cnt == 2'd2) dataLoShadow <= in_bits;
         end
         if (loadOut) begin
            inPacket_tx_header <= hdrShadow;
            inPacket_tx_addr   <= addrShadow;
            inPacket_tx_data   <= {in_bits, dataLoShadow};
            out_valid          <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_packet_deserializer.sv
// Testbench for packet_deserializer: vector table, directed corner
// sequences and a randomized run against a frame-level model.
module tb_packet_deserializer;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bits;
   logic        in_last;
   logic [15:0] hdr;
   logic [15:0] addr;
   logic [31:0] data;
   logic        out_valid;
   logic        out_ready;
   logic        err_pulse;
   logic [1:0]  err_count;

   int checks = 0;
   int errors = 0;

   packet_deserializer #(.ERR_CNT_W(2)) dut (
      .clock              (clock),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_bits            (in_bits),
      .in_last            (in_last),
      .inPacket_tx_header (hdr),
      .inPacket_tx_addr   (addr),
      .inPacket_tx_data   (data),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .err_pulse          (err_pulse),
      .err_count          (err_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [15:0] b;
      logic        l;
      logic        oR;
      logic        eRdy;
      logic        eOv;
      logic [15:0] eH;
      logic [15:0] eA;
      logic [31:0] eD;
      logic        eP;
      logic [1:0]  eC;
   } vecT;

   typedef struct {
      logic [15:0] h;
      logic [15:0] a;
      logic [31:0] d;
   } pktT;

   vecT vec[$];

   function automatic vecT mk(logic v, logic [15:0] b, logic l,
                              logic oR, logic eRdy, logic eOv,
                              logic [15:0] eH, logic [15:0] eA,
                              logic [31:0] eD, logic eP,
                              logic [1:0] eC);
      vecT r;
      r.v = v; r.b = b; r.l = l; r.oR = oR;
      r.eRdy = eRdy; r.eOv = eOv; r.eH = eH; r.eA = eA;
      r.eD = eD; r.eP = eP; r.eC = eC;
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", n, a, e);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] b,
                        input logic l, input logic oR);
      in_valid = v; in_bits = b; in_last = l; out_ready = oR;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chkOut(input string n, input logic [15:0] h,
                         input logic [15:0] a, input logic [31:0] d);
      chk({n, ".hdr"}, {16'h0, hdr}, {16'h0, h});
      chk({n, ".addr"}, {16'h0, addr}, {16'h0, a});
      chk({n, ".data"}, data, d);
   endtask

   task automatic doReset;
      reset = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      tick;
      tick;
      reset = 1'b1;
   endtask

   function automatic int sat(int e);
      return (e > 3) ? 3 : e;
   endfunction

   // frame-level reference model state
   logic [15:0] frame[$];
   pktT         expQ[$];
   bit          resync;
   int          errs;
   bit          expPulse;
   int          pulses;

   initial begin
      doReset;
      chk("reset.out_valid", {31'h0, out_valid}, 32'h0);
      chk("reset.err_pulse", {31'h0, err_pulse}, 32'h0);
      chk("reset.err_count", {30'h0, err_count}, 32'h0);
      chkOut("reset", 16'h0, 16'h0, 32'h0);

      // basic frame
      vec.push_back(mk(1, 16'hA5A5, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      vec.push_back(mk(1, 16'h0010, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      vec.push_back(mk(1, 16'hBEEF, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      vec.push_back(mk(1, 16'hDEAD, 1, 1, 1, 1, 16'hA5A5, 16'h0010,
                       32'hDEADBEEF, 0, 0));
      vec.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      // short frame then good frame
      vec.push_back(mk(1, 16'h1111, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      vec.push_back(mk(1, 16'h2222, 1, 1, 1, 0, 0, 0, 0, 1, 1));
      vec.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'h0001, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'h0002, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'h0003, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'h0004, 1, 1, 1, 1, 16'h0001, 16'h0002,
                       32'h00040003, 0, 1));
      vec.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      // long frame, resync, then good frame
      vec.push_back(mk(1, 16'hAAAA, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'hBBBB, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'hCCCC, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 16'hDDDD, 0, 1, 1, 0, 0, 0, 0, 1, 2));
      vec.push_back(mk(1, 16'hEEEE, 0, 1, 1, 0, 0, 0, 0, 0, 2));
      vec.push_back(mk(1, 16'hFFFF, 1, 1, 1, 0, 0, 0, 0, 0, 2));
      vec.push_back(mk(1, 16'h1234, 0, 1, 1, 0, 0, 0, 0, 0, 2));
      vec.push_back(mk(1, 16'h5678, 0, 1, 1, 0, 0, 0, 0, 0, 2));
      vec.push_back(mk(1, 16'h9ABC, 0, 1, 1, 0, 0, 0, 0, 0, 2));
      vec.push_back(mk(1, 16'hDEF0, 1, 1, 1, 1, 16'h1234, 16'h5678,
                       32'hDEF09ABC, 0, 2));
      vec.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 2));

      for (int i = 0; i < vec.size(); i++) begin
         drive(vec[i].v, vec[i].b, vec[i].l, vec[i].oR);
         #1;
         chk($sformatf("vec%0d.in_ready", i), {31'h0, in_ready},
             {31'h0, vec[i].eRdy});
         tick;
         chk($sformatf("vec%0d.out_valid", i), {31'h0, out_valid},
             {31'h0, vec[i].eOv});
         chk($sformatf("vec%0d.err_pulse", i), {31'h0, err_pulse},
             {31'h0, vec[i].eP});
         chk($sformatf("vec%0d.err_count", i), {30'h0, err_count},
             {30'h0, vec[i].eC});
         if (vec[i].eOv)
            chkOut($sformatf("vec%0d", i), vec[i].eH, vec[i].eA, vec[i].eD);
      end

      // back-pressure: second frame stalls at its last beat
      drive(1, 16'h0101, 0, 0); tick;
      drive(1, 16'h0202, 0, 0); tick;
      drive(1, 16'h0303, 0, 0); tick;
      drive(1, 16'h0404, 1, 0); tick;
      chk("bp.first_valid", {31'h0, out_valid}, 32'h1);
      chkOut("bp.first", 16'h0101, 16'h0202, 32'h04040303);
      drive(1, 16'h1111, 0, 0); #1;
      chk("bp.b0_ready", {31'h0, in_ready}, 32'h1); tick;
      drive(1, 16'h2222, 0, 0); #1;
      chk("bp.b1_ready", {31'h0, in_ready}, 32'h1); tick;
      drive(1, 16'h3333, 0, 0); #1;
      chk("bp.b2_ready", {31'h0, in_ready}, 32'h1); tick;
      for (int i = 0; i < 3; i++) begin
         drive(1, 16'h4444, 1, 0); #1;
         chk("bp.stall_ready", {31'h0, in_ready}, 32'h0);
         tick;
         chk("bp.hold_valid", {31'h0, out_valid}, 32'h1);
         chkOut("bp.hold", 16'h0101, 16'h0202, 32'h04040303);
      end
      drive(1, 16'h4444, 1, 1); #1;
      chk("bp.release_ready", {31'h0, in_ready}, 32'h1);
      chkOut("bp.first_taken", 16'h0101, 16'h0202, 32'h04040303);
      tick;
      chk("bp.second_valid", {31'h0, out_valid}, 32'h1);
      chkOut("bp.second", 16'h1111, 16'h2222, 32'h44443333);
      drive(0, 16'h0, 0, 1); tick;
      chk("bp.drained", {31'h0, out_valid}, 32'h0);
      chk("bp.no_err", {30'h0, err_count}, 32'h2);

      // reset mid-frame
      drive(1, 16'h7777, 0, 1); tick;
      drive(1, 16'h8888, 0, 1); tick;
      reset = 1'b0;
      drive(0, 16'h0, 0, 1); tick;
      reset = 1'b1;
      chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst.err_count", {30'h0, err_count}, 32'h0);
      #1;
      chk("rst.in_ready", {31'h0, in_ready}, 32'h1);
      drive(1, 16'h0A0A, 0, 1); tick;
      drive(1, 16'h0B0B, 0, 1); tick;
      drive(1, 16'h0C0C, 0, 1); tick;
      drive(1, 16'h0D0D, 1, 1); tick;
      chk("rst.frame_valid", {31'h0, out_valid}, 32'h1);
      chkOut("rst.frame", 16'h0A0A, 16'h0B0B, 32'h0D0D0C0C);
      drive(0, 16'h0, 0, 1); tick;

      // saturation of a 2-bit counter
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 16'($urandom), 1, 1); tick;
         if (err_pulse) pulses++;
         chk("sat.count", {30'h0, err_count}, sat(i + 1));
         drive(0, 16'h0, 0, 1); tick;
         if (err_pulse) pulses++;
      end
      chk("sat.pulses", pulses, 5);
      chk("sat.no_out", {31'h0, out_valid}, 32'h0);

      // randomized run against frame-level model
      doReset;
      frame.delete();
      expQ.delete();
      resync = 0;
      errs = 0;
      for (int c = 0; c < 3000; c++) begin
         logic v;
         logic l;
         logic oR;
         logic [15:0] b;
         logic expRdy;
         v  = ($urandom_range(0, 9) < 7);
         b  = 16'($urandom);
         oR = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) == 0) l = 1'($urandom_range(0, 1));
         else if (resync)               l = ($urandom_range(0, 2) == 0);
         else                           l = (frame.size() == 3);
         drive(v, b, l, oR);
         #1;
         expRdy = resync || (frame.size() != 3) || (expQ.size() == 0) || oR;
         chk("rnd.in_ready", {31'h0, in_ready}, {31'h0, expRdy});
         if (expQ.size() > 0 && oR) begin
            chkOut("rnd.pkt", expQ[0].h, expQ[0].a, expQ[0].d);
            void'(expQ.pop_front());
         end
         expPulse = 0;
         if (v && expRdy) begin
            if (resync) begin
               if (l) resync = 0;
            end else begin
               frame.push_back(b);
               if (l) begin
                  if (frame.size() == 4) begin
                     pktT p;
                     p.h = frame[0];
                     p.a = frame[1];
                     p.d = {frame[3], frame[2]};
                     expQ.push_back(p);
                  end else begin
                     errs++;
                     expPulse = 1;
                  end
                  frame.delete();
               end else if (frame.size() == 4) begin
                  errs++;
                  expPulse = 1;
                  resync = 1;
                  frame.delete();
               end
            end
         end
         tick;
         chk("rnd.out_valid", {31'h0, out_valid},
             {31'h0, (expQ.size() != 0)});
         chk("rnd.err_pulse", {31'h0, err_pulse}, {31'h0, expPulse});
         chk("rnd.err_count", {30'h0, err_count}, sat(errs));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
